reg_sequencer: RTL and testbench
================================

Name: reg_sequencer

Overview:
- Upstream control stage for the register file; drives its x/y read ports and z write port.
- Accepts one register-register micro-op (op, x, y, z register numbers) per start/busy handshake.
- Reads both operands through the register file strobes and computes the result in an internal ALU.
- Writes the result back through a single z_enb pulse, then reports done and updates the zero/carry flags.

Parameters:
W  8  data width; matches the register file width
SEL_W  4  register select width; matches the register file selection bits

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 CMP
x_reg  in  SEL_W  first operand register number
y_reg  in  SEL_W  second operand register number
z_reg  in  SEL_W  destination register number
busy  out  1  high from the cycle after start is accepted through DONE
done  out  1  one-cycle completion pulse
zero  out  1  last result == 0
carry  out  1  carry/borrow/shift-out of last op
x_sel  out  SEL_W  register file x select
y_sel  out  SEL_W  register file y select
z_sel  out  SEL_W  register file z select
x_enb  out  1  register file x read strobe
y_enb  out  1  register file y read strobe
z_enb  out  1  register file write strobe
x_data  in  W  register file x_out
y_data  in  W  register file y_out
z_data  out  W  register file z_in

Behaviour:
- All outputs are registered. Reset forces every output and all internal operand registers to 0 and the state to IDLE.
- Reset mid-operation aborts at once. If z_enb was high, it drops in the reset cycle, and the write already strobed stands.
- Cycle numbering: edge 0 is the edge that accepts start; cycle k is the interval after edge k.
- IDLE:
  - busy = 0.
  - start = 1 captures op, x_reg, y_reg and z_reg, then goes to READ_SEL.
- READ_SEL (cycle 0):
  - busy = 1; x_sel/y_sel driven from the captured values; strobes low (select setup).
- READ_STB (cycle 1): x_enb = y_enb = 1 for exactly one cycle.
- READ_CAP (cycle 2): strobes low; x_data/y_data latched into operand registers at the end of the cycle.
- EXEC (cycle 3):
  - Result and flags are registered at the end of the cycle.
  - z_sel and z_data are valid from cycle 4 and held until the next EXEC.
  - Next state is WRITE_STB, or DONE for CMP.
- WRITE_STB (cycle 4): z_enb = 1 for exactly one cycle; z_sel/z_data stable.
- DONE (cycle 5, or 4 for CMP):
  - z_enb = 0 with z_sel/z_data still held, so the falling edge sees stable selects.
  - done = 1, busy = 1; next state is IDLE.
- Throughput:
  - Next start is accepted at edge 7 (edge 6 for CMP).
  - start while busy is ignored, not queued.
- Arithmetic, computed at W+1 bits:
  - MOV: result = x; carry = 0.
  - ADD: result = x+y mod 2^W; carry = bit W of the sum.
  - SUB: result = x-y mod 2^W; carry = 1 iff x < y (unsigned borrow).
  - AND/OR/XOR: carry = 0.
  - SHL: result = x<<1 with LSB 0; carry = x[W-1].
  - CMP: same as SUB for the flags; z_enb is never asserted and z_data is unchanged.
  - zero = (result == 0) for every op.
- Flags change only at the end of EXEC.
- x_reg == y_reg is legal and both ports read the same register.
- z_reg equal to x_reg or y_reg is legal because the reads complete before the write.

Test Plan:
- r3=0xF0, r5=0x20, ADD x=3 y=5 z=7 -> r7=0x10, carry=1, zero=0; z_enb high only in cycle 4; done only in cycle 5.
- r2=0x42, SUB x=2 y=2 z=2 -> r2=0x00, zero=1, carry=0; x_enb/y_enb each high exactly one cycle.
- r1=0x05, r4=0x09, CMP x=1 y=4 -> carry=1, zero=0, z_enb never rises, done in cycle 4, all registers unchanged.
- r6=0x81, SHL x=6 z=6 -> r6=0x02, carry=1; start held high throughout -> second op accepted at edge 7, busy never drops mid-op.
- Reset asserted in cycle 2 of an ADD -> next cycle all outputs 0, state IDLE, no z_enb pulse, destination register unchanged.
- XOR 0xAA^0xAA, then MOV of 0x80 -> zero 1 then 0, carry 0 both times; flags constant between EXEC cycles.

Source files
------------

// File: rtl/reg_sequencer.sv
// Register-file sequencer: reads x/y operands, runs one ALU micro-op, writes the result to z.
// Latency: done pulses 5 cycles after start is accepted (4 for CMP); start is ignored while busy.
module reg_sequencer #(
    parameter int W     = 8,
    parameter int SEL_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SEL_W-1:0] x_reg,
    input  logic [SEL_W-1:0] y_reg,
    input  logic [SEL_W-1:0] z_reg,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic [SEL_W-1:0] x_sel,
    output logic [SEL_W-1:0] y_sel,
    output logic [SEL_W-1:0] z_sel,
    output logic             x_enb,
    output logic             y_enb,
    output logic             z_enb,
    input  logic [W-1:0]     x_data,
    input  logic [W-1:0]     y_data,
    output logic [W-1:0]     z_data
);

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_SEL,
        S_READ_STB,
        S_READ_CAP,
        S_EXEC,
        S_WRITE_STB,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic [SEL_W-1:0] x_sel_q, x_sel_d;
    logic [SEL_W-1:0] y_sel_q, y_sel_d;
    logic [SEL_W-1:0] z_sel_q, z_sel_d;
    logic             x_enb_q, x_enb_d;
    logic             y_enb_q, y_enb_d;
    logic             z_enb_q, z_enb_d;
    logic [W-1:0]     z_data_q, z_data_d;

    logic [W:0]       alu_ext;
    logic [W-1:0]     alu_res;
    logic             alu_c;

    // ALU evaluated at W+1 bits so bit W carries the add carry / sub borrow / shift-out.
    always_comb begin
        alu_ext = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_MOV: alu_ext = {1'b0, a_q};
            OP_ADD: begin
                alu_ext = {1'b0, a_q} + {1'b0, b_q};
                alu_c   = alu_ext[W];
            end
            OP_AND: alu_ext = {1'b0, a_q & b_q};
            OP_OR:  alu_ext = {1'b0, a_q | b_q};
            OP_XOR: alu_ext = {1'b0, a_q ^ b_q};
            OP_SHL: begin
                alu_ext = {a_q, 1'b0};
                alu_c   = alu_ext[W];
            end
            default: begin
                alu_ext = {1'b0, a_q} - {1'b0, b_q};
                alu_c   = alu_ext[W];
            end
        endcase
        alu_res = alu_ext[W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        x_sel_d  = x_sel_q;
        y_sel_d  = y_sel_q;
        z_sel_d  = z_sel_q;
        x_enb_d  = 1'b0;
        y_enb_d  = 1'b0;
        z_enb_d  = 1'b0;
        z_data_d = z_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    dst_d   = z_reg;
                    x_sel_d = x_reg;
                    y_sel_d = y_reg;
                    busy_d  = 1'b1;
                    state_d = S_READ_SEL;
                end
            end
            S_READ_SEL: begin
                x_enb_d = 1'b1;
                y_enb_d = 1'b1;
                state_d = S_READ_STB;
            end
            S_READ_STB: state_d = S_READ_CAP;
            S_READ_CAP: begin
                a_d     = x_data;
                b_d     = y_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                zero_d  = (alu_res == '0);
                carry_d = alu_c;
                // CMP only updates flags; the write-side outputs keep the previous result.
                if (op_q == OP_CMP) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    z_sel_d  = dst_q;
                    z_data_d = alu_res;
                    z_enb_d  = 1'b1;
                    state_d  = S_WRITE_STB;
                end
            end
            S_WRITE_STB: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            x_sel_q  <= '0;
            y_sel_q  <= '0;
            z_sel_q  <= '0;
            x_enb_q  <= 1'b0;
            y_enb_q  <= 1'b0;
            z_enb_q  <= 1'b0;
            z_data_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            x_sel_q  <= x_sel_d;
            y_sel_q  <= y_sel_d;
            z_sel_q  <= z_sel_d;
            x_enb_q  <= x_enb_d;
            y_enb_q  <= y_enb_d;
            z_enb_q  <= z_enb_d;
            z_data_q <= z_data_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign x_sel  = x_sel_q;
    assign y_sel  = y_sel_q;
    assign z_sel  = z_sel_q;
    assign x_enb  = x_enb_q;
    assign y_enb  = y_enb_q;
    assign z_enb  = z_enb_q;
    assign z_data = z_data_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: register-file model, expected events queued at issue, monitor pops on strobes/done.
module tb_reg_sequencer;

    localparam int W     = 8;
    localparam int SEL_W = 4;

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [SEL_W-1:0] x_reg, y_reg, z_reg;
    logic             busy, done, zero, carry;
    logic [SEL_W-1:0] x_sel, y_sel, z_sel;
    logic             x_enb, y_enb, z_enb;
    logic [W-1:0]     x_data, y_data, z_data;

    logic [W-1:0]     regs [16];
    logic             pl_en;
    logic [SEL_W-1:0] pl_sel;
    logic [W-1:0]     pl_dat;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int xcnt  = 0;
    int ycnt  = 0;
    int zcnt  = 0;

    typedef struct { logic [SEL_W-1:0] xs; logic [SEL_W-1:0] ys; int c; } rd_t;
    typedef struct { logic [SEL_W-1:0] zs; logic [W-1:0] d; int c; } wr_t;
    typedef struct { logic z; logic cy; int c; } dn_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    dn_t dn_q[$];
    rd_t mr;
    wr_t mw;
    dn_t md;

    reg_sequencer #(.W(W), .SEL_W(SEL_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .x_reg  (x_reg),
        .y_reg  (y_reg),
        .z_reg  (z_reg),
        .busy   (busy),
        .done   (done),
        .zero   (zero),
        .carry  (carry),
        .x_sel  (x_sel),
        .y_sel  (y_sel),
        .z_sel  (z_sel),
        .x_enb  (x_enb),
        .y_enb  (y_enb),
        .z_enb  (z_enb),
        .x_data (x_data),
        .y_data (y_data),
        .z_data (z_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (pl_en)
            regs[pl_sel] <= pl_dat;
        else if (z_enb)
            regs[z_sel] <= z_data;
    end

    assign x_data = regs[x_sel];
    assign y_data = regs[y_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or done pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (x_enb === 1'b1) xcnt++;
        if (y_enb === 1'b1) ycnt++;
        if (z_enb === 1'b1) zcnt++;
        if (x_enb === 1'b1 || y_enb === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else begin
                mr = rd_q.pop_front();
                check("read_both_strobes", 32'({x_enb, y_enb}), 32'd3);
                check("read_x_sel", 32'(x_sel), 32'(mr.xs));
                check("read_y_sel", 32'(y_sel), 32'(mr.ys));
                check("read_cycle", 32'(cyc), 32'(mr.c));
            end
        end
        if (z_enb === 1'b1) begin
            if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
                mw = wr_q.pop_front();
                check("write_z_sel", 32'(z_sel), 32'(mw.zs));
                check("write_z_data", 32'(z_data), 32'(mw.d));
                check("write_cycle", 32'(cyc), 32'(mw.c));
            end
        end
        if (done === 1'b1) begin
            if (dn_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                md = dn_q.pop_front();
                check("done_zero", 32'(zero), 32'(md.z));
                check("done_carry", 32'(carry), 32'(md.cy));
                check("done_cycle", 32'(cyc), 32'(md.c));
            end
        end
    end

    task automatic preload(input logic [SEL_W-1:0] s, input logic [W-1:0] d);
        @(negedge clock);
        pl_en  = 1'b1;
        pl_sel = s;
        pl_dat = d;
        @(negedge clock);
        pl_en  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [SEL_W-1:0] xr, input logic [SEL_W-1:0] yr,
                         input logic [SEL_W-1:0] zr, input bit hold, output int e0);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        x_reg = xr;
        y_reg = yr;
        z_reg = zr;
        @(posedge clock);
        #1;
        e0 = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic expect_op(input int e0, input logic [SEL_W-1:0] xr, input logic [SEL_W-1:0] yr,
                             input logic [SEL_W-1:0] zr, input logic [W-1:0] res,
                             input logic z, input logic c, input bit is_cmp);
        rd_q.push_back('{xr, yr, e0 + 1});
        if (!is_cmp) wr_q.push_back('{zr, res, e0 + 4});
        dn_q.push_back('{z, c, is_cmp ? e0 + 4 : e0 + 5});
    endtask

    // Called in cycle 0; returns at the falling edge of the done cycle.
    task automatic wait_done(input string name);
        bit   seen, busy_bad, flag_bad;
        logic z0, c0;
        seen = 0; busy_bad = 0; flag_bad = 0;
        z0 = zero;
        c0 = carry;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            if (busy !== 1'b1) busy_bad = 1;
            if (n <= 3 && (zero !== z0 || carry !== c0)) flag_bad = 1;
            if (done === 1'b1) seen = 1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_held"}, 32'(busy_bad), 32'd0);
        check({name, "_flags_stable"}, 32'(flag_bad), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [SEL_W-1:0] xr,
                          input logic [SEL_W-1:0] yr, input logic [SEL_W-1:0] zr,
                          input logic [W-1:0] res, input logic z, input logic c);
        int e0, x0, y0, zc0;
        bit is_cmp;
        is_cmp = (o == OP_CMP);
        x0 = xcnt; y0 = ycnt; zc0 = zcnt;
        issue(o, xr, yr, zr, 1'b0, e0);
        expect_op(e0, xr, yr, zr, res, z, c, is_cmp);
        wait_done(name);
        @(posedge clock);
        #1;
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_flags_after"}, 32'({zero, carry}), 32'({z, c}));
        check({name, "_x_strobes"}, 32'(xcnt - x0), 32'd1);
        check({name, "_y_strobes"}, 32'(ycnt - y0), 32'd1);
        check({name, "_z_strobes"}, 32'(zcnt - zc0), is_cmp ? 32'd0 : 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int   e0, x0, zc0;
        logic zf, cf;
        bit   flag_bad;

        reset = 1'b1; start = 1'b0; op = '0;
        x_reg = '0; y_reg = '0; z_reg = '0;
        pl_en = 1'b0; pl_sel = '0; pl_dat = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              32'({busy, done, zero, carry, x_sel, y_sel, z_sel, x_enb, y_enb, z_enb, z_data}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ADD with carry out
        preload(4'd3, 8'hF0);
        preload(4'd5, 8'h20);
        preload(4'd7, 8'h00);
        run_op("add", OP_ADD, 4'd3, 4'd5, 4'd7, 8'h10, 1'b0, 1'b1);
        check("add_r7", 32'(regs[7]), 32'h10);

        // SUB of a register with itself, writing back to the same register
        preload(4'd2, 8'h42);
        run_op("sub", OP_SUB, 4'd2, 4'd2, 4'd2, 8'h00, 1'b1, 1'b0);
        check("sub_r2", 32'(regs[2]), 32'h00);

        // CMP: flags only, write side untouched
        preload(4'd1, 8'h05);
        preload(4'd4, 8'h09);
        preload(4'd13, 8'h77);
        run_op("cmp", OP_CMP, 4'd1, 4'd4, 4'd13, 8'hFC, 1'b0, 1'b1);
        check("cmp_z_hold", 32'({z_sel, z_data}), 32'({4'd2, 8'h00}));
        check("cmp_regs", 32'({regs[1], regs[4], regs[13]}), 32'h050977);

        // SHL with start held high: second op accepted at edge 7
        preload(4'd6, 8'h81);
        x0 = xcnt; zc0 = zcnt;
        issue(OP_SHL, 4'd6, 4'd6, 4'd6, 1'b1, e0);
        expect_op(e0, 4'd6, 4'd6, 4'd6, 8'h02, 1'b0, 1'b1, 1'b0);
        expect_op(e0 + 7, 4'd6, 4'd6, 4'd6, 8'h04, 1'b0, 1'b0, 1'b0);
        wait_done("shl1");
        @(posedge clock);
        #1;
        check("shl1_idle_cycle6", 32'(busy), 32'd0);
        check("shl1_flags", 32'({zero, carry}), 32'({1'b0, 1'b1}));
        @(posedge clock);
        #1;
        check("shl2_accept_edge7", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("shl2");
        @(posedge clock);
        #1;
        check("shl2_busy_after", 32'(busy), 32'd0);
        check("shl2_flags", 32'({zero, carry}), 32'({1'b0, 1'b0}));
        check("shl_r6", 32'(regs[6]), 32'h04);
        check("shl_x_strobes", 32'(xcnt - x0), 32'd2);
        check("shl_z_strobes", 32'(zcnt - zc0), 32'd2);

        // Reset during READ_CAP of an ADD aborts it
        preload(4'd12, 8'h5A);
        zc0 = zcnt;
        issue(OP_ADD, 4'd3, 4'd5, 4'd12, 1'b0, e0);
        rd_q.push_back('{4'd3, 4'd5, e0 + 1});
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_outputs",
              32'({busy, done, zero, carry, x_sel, y_sel, z_sel, x_enb, y_enb, z_enb, z_data}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_r12", 32'(regs[12]), 32'h5A);
        check("abort_no_write", 32'(zcnt - zc0), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);

        // XOR to zero, flags hold while idle, then MOV of a nonzero value
        preload(4'd8, 8'hAA);
        preload(4'd10, 8'h80);
        run_op("xor", OP_XOR, 4'd8, 4'd8, 4'd9, 8'h00, 1'b1, 1'b0);
        zf = zero; cf = carry; flag_bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (zero !== zf || carry !== cf) flag_bad = 1;
        end
        check("idle_flags_stable", 32'(flag_bad), 32'd0);
        run_op("mov", OP_MOV, 4'd10, 4'd10, 4'd11, 8'h80, 1'b0, 1'b0);
        check("xor_mov_regs", 32'({regs[9], regs[11]}), 32'h0080);

        repeat (2) @(negedge clock);
        check("queues_drained", 32'(rd_q.size() + wr_q.size() + dn_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
